// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter: 3-stage Sobel |Gx|+|Gy| with saturation, threshold and frame-done pulse
module sobel_edge_filter #(
    parameter int P_FRAME_COLUMNS     = 640,
    parameter int P_FRAME_ROWS        = 480,
    parameter int P_SUBPIXEL_DEPTH    = 8,
    parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
    parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
    parameter int P_MATRIX_BITS       = 8*P_SUBPIXEL_DEPTH
) (
    input  logic                           I_CLK,
    input  logic                           I_RESET,
    input  logic [P_FRAME_COLUMN_BITS-1:0] I_PIXEL_COLUMN,
    input  logic [P_FRAME_ROW_BITS-1:0]    I_PIXEL_ROW,
    input  logic [P_MATRIX_BITS-1:0]       I_PIXEL_MATRIX,
    input  logic                           I_PIXEL_MATRIX_READY,
    input  logic [P_SUBPIXEL_DEPTH-1:0]    I_THRESHOLD,
    output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
    output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
    output logic [P_SUBPIXEL_DEPTH-1:0]    O_PIXEL,
    output logic                           O_PIXEL_EDGE,
    output logic                           O_PIXEL_READY,
    output logic                           O_FRAME_DONE
);
    localparam int D = P_SUBPIXEL_DEPTH;

    logic [D-1:0] tl, t, tr, ml, mr, bl, b, br;
    logic [D+1:0] gx_p, gx_n, gy_p, gy_n;
    logic         last;

    logic [D+1:0]                   s1_gx_p, s1_gx_n, s1_gy_p, s1_gy_n;
    logic [P_FRAME_COLUMN_BITS-1:0] s1_col, s2_col;
    logic [P_FRAME_ROW_BITS-1:0]    s1_row, s2_row;
    logic [D-1:0]                   s1_thr, s2_thr;
    logic                           s1_valid, s1_last, s2_valid, s2_last;

    logic [D+1:0] ax, ay, s2_ax, s2_ay;
    logic [D+2:0] mag;
    logic [D-1:0] pix;

    always_comb begin
        {tl, t, tr, ml, mr, bl, b, br} = I_PIXEL_MATRIX;
        gx_p = {2'b0, tr} + {1'b0, mr, 1'b0} + {2'b0, br};
        gx_n = {2'b0, tl} + {1'b0, ml, 1'b0} + {2'b0, bl};
        gy_p = {2'b0, bl} + {1'b0, b, 1'b0}  + {2'b0, br};
        gy_n = {2'b0, tl} + {1'b0, t, 1'b0}  + {2'b0, tr};
        last = (I_PIXEL_COLUMN == P_FRAME_COLUMN_BITS'(P_FRAME_COLUMNS-3)) &&
               (I_PIXEL_ROW == P_FRAME_ROW_BITS'(P_FRAME_ROWS-3));
        ax   = (s1_gx_p >= s1_gx_n) ? s1_gx_p - s1_gx_n : s1_gx_n - s1_gx_p;
        ay   = (s1_gy_p >= s1_gy_n) ? s1_gy_p - s1_gy_n : s1_gy_n - s1_gy_p;
        mag  = {1'b0, s2_ax} + {1'b0, s2_ay};
        pix  = (|mag[D+2:D]) ? {D{1'b1}} : mag[D-1:0];
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            s1_gx_p <= '0; s1_gx_n <= '0; s1_gy_p <= '0; s1_gy_n <= '0;
            s1_col <= '0; s1_row <= '0; s1_thr <= '0; s1_valid <= 1'b0; s1_last <= 1'b0;
            s2_ax <= '0; s2_ay <= '0;
            s2_col <= '0; s2_row <= '0; s2_thr <= '0; s2_valid <= 1'b0; s2_last <= 1'b0;
            O_PIXEL_COLUMN <= '0;
            O_PIXEL_ROW    <= '0;
            O_PIXEL        <= '0;
            O_PIXEL_EDGE   <= 1'b0;
            O_PIXEL_READY  <= 1'b0;
            O_FRAME_DONE   <= 1'b0;
        end else begin
            s1_gx_p  <= gx_p;
            s1_gx_n  <= gx_n;
            s1_gy_p  <= gy_p;
            s1_gy_n  <= gy_n;
            s1_col   <= I_PIXEL_COLUMN + 1'b1;
            s1_row   <= I_PIXEL_ROW + 1'b1;
            s1_thr   <= I_THRESHOLD;
            s1_valid <= I_PIXEL_MATRIX_READY;
            s1_last  <= I_PIXEL_MATRIX_READY & last;
            s2_ax    <= ax;
            s2_ay    <= ay;
            s2_col   <= s1_col;
            s2_row   <= s1_row;
            s2_thr   <= s1_thr;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            O_PIXEL_COLUMN <= s2_col;
            O_PIXEL_ROW    <= s2_row;
            O_PIXEL        <= pix;
            O_PIXEL_EDGE   <= pix >= s2_thr;
            O_PIXEL_READY  <= s2_valid;
            O_FRAME_DONE   <= s2_valid & s2_last;
        end
    end
endmodule
